// File: rtl/phase_to_sincos.sv
// ============================================================================
// phase_to_sincos
// ----------------------------------------------------------------------------
// Converts a stream of phase words in scaled radians into sin/cos samples. It
// sits after the phase accumulator and feeds the NCO mixer / DDS output path.
//
// Phase format: Q2.(WIDTH_IN-3), where 1.0 = pi. Only the low WIDTH_IN-2 bits
// are used, so one turn (2.0) wraps silently. This makes +1.0 and -1.0 the same
// angle.
//
// The phase is split into three fields:
//   q = quadrant      = p[WIDTH_IN-3 : WIDTH_IN-4]
//   k = ROM address   = p[WIDTH_IN-5 -: LUT_ADDR]
//   lower bits        = truncated
//
// The quarter-wave ROM holds S[k] = round(FS * sin(pi/2 * (k+0.5) / 2**LUT_ADDR)),
// with FS = 2**(WIDTH_OUT-1)-1. Because of the half-LSB offset, the table read
// backwards is the cosine: C[k] = S[~k]. Both ROM ports are read every cycle,
// and the quadrant then selects and negates the two values.
//
// Pipeline (3 cycles, 1 sample/cycle, AXI-stream on both sides):
//   S1  registers {q, k, ~k, tlast}
//   S2  registered reads of both ROM ports (block-RAM friendly)
//   S3  applies the signs; all o_* outputs come straight from S3 registers
// A stage loads when it is empty or when its content leaves in the same cycle.
// This collapses bubbles behind a stalled output. i_tready depends
// combinationally on o_tready.
//
// Optional build macro:
//   PHASE_TO_SINCOS_ROUND_EN  When defined, half an address LSB is added to
//                             the phase before folding, modulo one turn. This
//                             gives round-to-nearest addressing. When undefined,
//                             the phase is truncated. Latency is unchanged.
//
// Ports:
//   clk       in   1            clock
//   reset_n   in   1            asynchronous active-low reset
//   clear     in   1            synchronous flush of all stage valids
//   i_tdata   in   WIDTH_IN     phase word
//   i_tlast   in   1            carried alongside its sample unmodified
//   i_tvalid  in   1            input valid
//   i_tready  out  1            input ready (low while clear is high)
//   o_tdata   out  2*WIDTH_OUT  {cos, sin}, two's complement
//   o_tlast   out  1            tlast of the sample on o_tdata
//   o_tvalid  out  1            output valid
//   o_tready  in   1            output ready
// ============================================================================
module phase_to_sincos #(
    parameter int WIDTH_IN  = 16,  // phase width; requires LUT_ADDR <= WIDTH_IN-4
    parameter int LUT_ADDR  = 10,  // log2 of quarter-wave ROM depth
    parameter int WIDTH_OUT = 16   // width of each of sin and cos
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [WIDTH_IN-1:0]    i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [2*WIDTH_OUT-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready
);

    localparam int PH_W      = WIDTH_IN - 2;   // bits spanning exactly one turn
    localparam int ROM_DEPTH = 2 ** LUT_ADDR;
    localparam int ROM_W     = WIDTH_OUT - 1;  // |S| <= FS fits without a sign bit

    // ------------------------------------------------------------------------
    // ROM contents, computed at elaboration time.
    //
    // The sine is evaluated with an integer Taylor series in 60-bit fixed
    // point, so no real-number math is needed in the synthesis flow. The
    // truncation error is around 2^-55, far below the output LSB.
    // ------------------------------------------------------------------------
    localparam int           FRAC  = 60;
    localparam logic [127:0] PI_FX = 128'h3243_F6A8_885A_308D;  // pi * 2^60
    localparam logic [127:0] FS_FX = (128'd1 << (WIDTH_OUT - 1)) - 128'd1;

    function automatic logic [ROM_W-1:0] rom_entry(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc_pos;
        logic [127:0] acc_neg;
        logic [127:0] mag;
        // Angle = pi * (2k+1) / 2^(LUT_ADDR+2), i.e. pi/2 * (k+0.5) / 2^LUT_ADDR
        x       = (PI_FX * (128'(k) * 128'd2 + 128'd1)) >> (LUT_ADDR + 2);
        x2      = (x * x) >> FRAC;
        term    = x;
        acc_pos = x;
        acc_neg = '0;
        // Terms alternate in sign. Positive and negative parts are kept in
        // separate accumulators so that all arithmetic stays unsigned.
        for (int n = 1; n <= 15; n++) begin
            term = ((term * x2) >> FRAC) / 128'(2 * n * (2 * n + 1));
            if (n[0]) acc_neg = acc_neg + term;
            else      acc_pos = acc_pos + term;
        end
        mag = ((acc_pos - acc_neg) * FS_FX + (128'd1 << (FRAC - 1))) >> FRAC;
        return mag[ROM_W-1:0];
    endfunction

    logic [ROM_W-1:0] w_rom [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam logic [ROM_W-1:0] ENTRY = rom_entry(g);
        assign w_rom[g] = ENTRY;
    end

    // ------------------------------------------------------------------------
    // Handshake: each stage advances when it is empty or its content moves on
    // ------------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;
    logic w_accept, w_ld2, w_ld3;

    assign w_adv3   = ~r_v3 | o_tready;
    assign w_adv2   = ~r_v2 | w_adv3;
    assign w_adv1   = ~r_v1 | w_adv2;      // = ~(all three valid) | o_tready
    assign i_tready = w_adv1 & ~clear;     // a flushed cycle must not consume input
    assign w_accept = i_tvalid & i_tready;
    assign w_ld2    = w_adv2 & r_v1 & ~clear;
    assign w_ld3    = w_adv3 & r_v2 & ~clear;

    // NOTE: non-blocking assignments in every clocked block, so that each stage
    // samples the pre-edge value of the previous one. Blocking assignments here
    // would let a sample ripple through several stages in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (clear) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= w_accept;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    // ------------------------------------------------------------------------
    // S1: optional rounding, then field extraction
    // ------------------------------------------------------------------------
    logic [PH_W-1:0] w_phase;

`ifdef PHASE_TO_SINCOS_ROUND_EN
    // Half an address LSB. This is zero when there are no bits below k.
    localparam logic [PH_W-1:0] PH_HALF =
        (LUT_ADDR < WIDTH_IN - 4) ? (PH_W'(1) << (WIDTH_IN - 5 - LUT_ADDR)) : '0;
    assign w_phase = i_tdata[PH_W-1:0] + PH_HALF;  // the carry out is the turn wrap
`else
    assign w_phase = i_tdata[PH_W-1:0];
`endif

    // The turn bits and the sub-address bits intentionally do not reach any logic.
    logic w_unused;
    assign w_unused = ^{i_tdata[WIDTH_IN-1 -: 2], w_phase};

    logic [1:0]          r_s1_q;
    logic [LUT_ADDR-1:0] r_s1_k;
    logic [LUT_ADDR-1:0] r_s1_nk;
    logic                r_s1_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_q    <= '0;
            r_s1_k    <= '0;
            r_s1_nk   <= '0;
            r_s1_last <= 1'b0;
        end else if (w_accept) begin
            r_s1_q    <= w_phase[PH_W-1 -: 2];
            r_s1_k    <= w_phase[PH_W-3 -: LUT_ADDR];
            r_s1_nk   <= ~w_phase[PH_W-3 -: LUT_ADDR];
            r_s1_last <= i_tlast;
        end
    end

    // ------------------------------------------------------------------------
    // S2: registered ROM reads, with control fields carried alongside
    // ------------------------------------------------------------------------
    logic [1:0]       r_s2_q;
    logic             r_s2_last;
    logic [ROM_W-1:0] r_s2_sk;    // S[k]
    logic [ROM_W-1:0] r_s2_snk;   // S[~k]

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_q    <= '0;
            r_s2_last <= 1'b0;
        end else if (w_ld2) begin
            r_s2_q    <= r_s1_q;
            r_s2_last <= r_s1_last;
        end
    end

    // NOTE: the ROM output registers have no reset. A reset would prevent them
    // from mapping onto block-RAM output registers. Their contents are never
    // observed unless the valid bit beside them is set.
    always_ff @(posedge clk) begin
        if (w_ld2) begin
            r_s2_sk  <= w_rom[r_s1_k];
            r_s2_snk <= w_rom[r_s1_nk];
        end
    end

    // ------------------------------------------------------------------------
    // S3: quadrant folding
    //   q=0: sin=+S[k]   cos=+S[~k]
    //   q=1: sin=+S[~k]  cos=-S[k]
    //   q=2: sin=-S[k]   cos=-S[~k]
    //   q=3: sin=-S[~k]  cos=+S[k]
    // Negation cannot overflow, because |S| <= FS.
    // ------------------------------------------------------------------------
    logic [WIDTH_OUT-1:0] w_sin_mag, w_cos_mag;
    logic [WIDTH_OUT-1:0] w_sin, w_cos;

    // NOTE: every always_comb output gets a default value first. Then no path
    // leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        w_sin_mag = {1'b0, r_s2_sk};
        w_cos_mag = {1'b0, r_s2_snk};
        if (r_s2_q[0]) begin
            w_sin_mag = {1'b0, r_s2_snk};
            w_cos_mag = {1'b0, r_s2_sk};
        end
        w_sin = r_s2_q[1]               ? -w_sin_mag : w_sin_mag;
        w_cos = (r_s2_q[1] ^ r_s2_q[0]) ? -w_cos_mag : w_cos_mag;
    end

    logic [WIDTH_OUT-1:0] r_s3_sin;
    logic [WIDTH_OUT-1:0] r_s3_cos;
    logic                 r_s3_last;

    // These registers load only when a new sample enters. The output therefore
    // holds steady while it is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_sin  <= '0;
            r_s3_cos  <= '0;
            r_s3_last <= 1'b0;
        end else if (w_ld3) begin
            r_s3_sin  <= w_sin;
            r_s3_cos  <= w_cos;
            r_s3_last <= r_s2_last;
        end
    end

    assign o_tdata  = {r_s3_cos, r_s3_sin};
    assign o_tlast  = r_s3_last;
    assign o_tvalid = r_v3;

endmodule

// File: tb/tb_phase_to_sincos.sv
// ============================================================================
// tb_phase_to_sincos
// ----------------------------------------------------------------------------
// Directed bench for phase_to_sincos, using default parameters (16/10/16).
// Sections:
//   - Reset values.
//   - A table of hand-computed phase vectors, each also timed for latency.
//   - Backpressure fill and release.
//   - A 100-sample stream with random o_tready, scored against a
//     real-arithmetic model.
//   - Clear flush.
//   - Asynchronous reset in the middle of the stream.
// ============================================================================
module tb_phase_to_sincos;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [15:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    int n_tests = 0;
    int n_fail  = 0;

    phase_to_sincos dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Model: the full-circle angle at the centre of the addressed ROM cell,
    // evaluated directly. Returns {tlast, cos, sin}.
    function automatic logic [32:0] exp_word(input logic [15:0] p, input logic last);
        logic [13:0] ph;
        real         a;
        int          s;
        int          c;
        ph = p[13:0];
`ifdef PHASE_TO_SINCOS_ROUND_EN
        ph = ph + 14'd2;
`endif
        a = 2.0 * 3.14159265358979323846 * (real'(ph[13:2]) + 0.5) / 4096.0;
        s = rnd(32767.0 * $sin(a));
        c = rnd(32767.0 * $cos(a));
        return {last, 16'(c), 16'(s)};
    endfunction

    typedef struct {
        logic [15:0] phase;
        logic        last;
        int          sin_v;
        int          cos_v;
    } vec_t;

    // Sends one sample with o_tready high. Returns the number of edges from the
    // accepting edge until o_tvalid is seen, or 10 if it never appears.
    task automatic send_one(input logic [15:0] ph, input logic last, output int lat,
                            output logic [31:0] data, output logic lst);
        @(negedge clk);
        o_tready = 1'b1;
        i_tdata  = ph;
        i_tlast  = last;
        i_tvalid = 1'b1;
        @(negedge clk);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        lat = 1;
        while (!o_tvalid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        data = o_tdata;
        lst  = o_tlast;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [15:0] bp_ph[3];
        int          lat;
        logic [31:0] data;
        logic        lst;
        int          acc;
        int          tx;
        int          rx;
        int          cyc;
        int          extra;
        logic        prev_stall;
        logic [32:0] prev_word;

        vecs[0] = '{16'h0000, 1'b0,     25,  32767};
        vecs[1] = '{16'h1000, 1'b1,  32767,    -25};
        vecs[2] = '{16'h2000, 1'b0,    -25, -32767};
        vecs[3] = '{16'hE000, 1'b1,    -25, -32767};
        vecs[4] = '{16'hF000, 1'b0, -32767,     25};
        vecs[5] = '{16'h3000, 1'b0, -32767,     25};
        vecs[6] = '{16'h0FFC, 1'b1,  32767,     25};
        vecs[7] = '{16'h4000, 1'b0,     25,  32767};
`ifdef PHASE_TO_SINCOS_ROUND_EN
        vecs[8] = '{16'h0003, 1'b0,     75,  32767};
        vecs[9] = '{16'h3FFE, 1'b1,     25,  32767};
`else
        vecs[8] = '{16'h0003, 1'b0,     25,  32767};
        vecs[9] = '{16'h3FFE, 1'b1,    -25,  32767};
`endif
        bp_ph[0] = 16'h0000;
        bp_ph[1] = 16'h1000;
        bp_ph[2] = 16'h2000;

        // ---- reset ----
        reset_n  = 1'b1;
        clear    = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tvalid", o_tvalid, 0);
        check("reset_tdata", o_tdata, 0);
        check("reset_tlast", o_tlast, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_tready", i_tready, 1);
        check("reset_idle_tvalid", o_tvalid, 0);

        // ---- directed table ----
        foreach (vecs[i]) begin
            send_one(vecs[i].phase, vecs[i].last, lat, data, lst);
            check($sformatf("lat[%0h]", vecs[i].phase), lat, 3);
            check($sformatf("sin[%0h]", vecs[i].phase), int'($signed(data[15:0])), vecs[i].sin_v);
            check($sformatf("cos[%0h]", vecs[i].phase), int'($signed(data[31:16])), vecs[i].cos_v);
            check($sformatf("last[%0h]", vecs[i].phase), lst, vecs[i].last);
        end

        // ---- backpressure: fill, then release ----
        @(negedge clk);
        o_tready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            i_tvalid = 1'b1;
            i_tlast  = 1'b0;
            i_tdata  = (acc < 3) ? bp_ph[acc] : 16'h3000;
            #1;
            if (i_tready) acc++;
            @(negedge clk);
        end
        check("bp_accepted", acc, 3);
        check("bp_tready_low", i_tready, 0);
        check("bp_tvalid", o_tvalid, 1);
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        #1;
        check("bp_tready_release", i_tready, 1);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("bp_valid%0d", j), o_tvalid, 1);
            check($sformatf("bp_data%0d", j), {o_tlast, o_tdata}, exp_word(bp_ph[j], 1'b0));
            @(negedge clk);
        end
        check("bp_drained", o_tvalid, 0);

        // ---- stream of 100 with random output stalls ----
        tx = 0;
        rx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_word = '0;
        while (rx < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall)
                check("stall_hold", {o_tvalid, o_tlast, o_tdata}, {1'b1, prev_word});
            o_tready = 1'($urandom_range(0, 1));
            i_tvalid = (tx < 100);
            i_tdata  = 16'(tx * 512);
            i_tlast  = (tx == 99);
            #1;
            if (o_tvalid && o_tready) begin
                check($sformatf("stream[%0d]", rx), {o_tlast, o_tdata},
                      exp_word(16'(rx * 512), rx == 99));
                rx++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_word  = {o_tlast, o_tdata};
            if (i_tvalid && i_tready) tx++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        check("stream_count", rx, 100);
        o_tready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_tvalid) extra++;
        end
        check("stream_extra", extra, 0);

        // ---- clear with three samples in flight ----
        @(negedge clk);
        o_tready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_tvalid = 1'b1;
            i_tdata  = bp_ph[j];
            @(negedge clk);
        end
        check("clear_pre_valid", o_tvalid, 1);
        clear    = 1'b1;
        i_tdata  = 16'h3000;
        #1;
        check("clear_tready", i_tready, 0);
        @(negedge clk);
        clear    = 1'b0;
        i_tvalid = 1'b0;
        check("clear_flush", o_tvalid, 0);
        o_tready = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_tvalid) extra++;
        end
        check("clear_no_ghost", extra, 0);

        // ---- asynchronous reset mid-stream ----
        @(negedge clk);
        o_tready = 1'b1;
        i_tvalid = 1'b1;
        i_tlast  = 1'b1;
        i_tdata  = 16'h1000;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        check("arst_pre_valid", o_tvalid, 1);
        check("arst_pre_last", o_tlast, 1);
        reset_n = 1'b0;
        #1;
        check("arst_tvalid", o_tvalid, 0);
        check("arst_tdata", o_tdata, 0);
        check("arst_tlast", o_tlast, 0);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("arst_tready", i_tready, 1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_tvalid) extra++;
        end
        check("arst_quiet", extra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
